// File: rtl/clk_divisor_prog_pkg.sv
// Shared constants, state encoding and helpers for the programmable clock divider.
package clk_divisor_prog_pkg;

   localparam int unsigned DIV_W_DEF   = 8;
   localparam int unsigned DEF_DIV_DEF = 4;
   localparam int unsigned MIN_DIV     = 2;

   typedef enum logic [0:0] {
      StStop = 1'b0,
      StRun  = 1'b1
   } state_t;

   // Number of high cycles in a period of n; odd n gets the extra high cycle.
   function automatic int unsigned ceil_half(input int unsigned n);
      return (n / 2) + (n % 2);
   endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter: counts 0..limit-1 while enabled, flags the last count as a wrap.
module clk_div_counter #(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk_hf,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [DIV_W-1:0] limit,
   output logic [DIV_W-1:0] count,
   output logic             wrap
);

   always_comb begin
      wrap = (count == (limit - 1'b1));
   end

   always_ff @(posedge clk_hf) begin
      if (!rst_n || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= wrap ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/clk_divisor_prog.sv
// Programmable clock divider with a valid/ready divisor port; new divisors take
// effect only at period boundaries so the divided clock never glitches.
module clk_divisor_prog
   import clk_divisor_prog_pkg::*;
#(
   parameter int unsigned DIV_W   = DIV_W_DEF,
   parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
   input  logic             clk_hf,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div_in,
   input  logic             div_valid,
   output logic             div_ready,
   output logic             div_err,
   output logic             clk,
   output logic             tick,
   output logic             running
);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] n_q, n_d;
   logic [DIV_W-1:0] p_q, p_d;
   logic [DIV_W-1:0] cnt, cnt_d;
   logic             pending_q, pending_d;
   logic             wrap, run_wrap, apply, accept, legal;

   clk_div_counter #(
      .DIV_W (DIV_W)
   ) u_counter (
      .clk_hf (clk_hf),
      .rst_n  (rst_n),
      .clear  (state_q == StStop),
      .enable (state_q == StRun),
      .limit  (n_q),
      .count  (cnt),
      .wrap   (wrap)
   );

   always_comb begin
      run_wrap  = (state_q == StRun) && wrap;
      accept    = div_valid && div_ready;
      legal     = (32'(div_in) >= MIN_DIV);
      apply     = pending_q && ((state_q == StStop) || run_wrap);
      n_d       = apply ? p_q : n_q;
      p_d       = p_q;
      pending_d = pending_q;
      if (apply) begin
         pending_d = 1'b0;
      end else if (accept && legal) begin
         p_d       = div_in;
         pending_d = 1'b1;
      end

      state_d = state_q;
      unique case (state_q)
         StStop:  if (en) state_d = StRun;
         StRun:   if (run_wrap && !en) state_d = StStop;
         default: state_d = StStop;
      endcase

      // Mirrors the counter's next value so outputs can be registered in phase with it.
      cnt_d = ((state_q == StStop) || wrap) ? '0 : cnt + 1'b1;
   end

   always_ff @(posedge clk_hf) begin
      if (!rst_n) begin
         state_q   <= StStop;
         n_q       <= DIV_W'(DEF_DIV);
         p_q       <= '0;
         pending_q <= 1'b0;
         div_ready <= 1'b1;
         div_err   <= 1'b0;
         clk       <= 1'b0;
         tick      <= 1'b0;
         running   <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         p_q       <= p_d;
         pending_q <= pending_d;
         div_ready <= !pending_d;
         div_err   <= accept && !legal;
         clk       <= (state_d == StRun) && (32'(cnt_d) < ceil_half(32'(n_d)));
         tick      <= (state_d == StRun) && (cnt_d == '0);
         running   <= (state_d == StRun);
      end
   end

endmodule

// File: tb/tb_clk_divisor_prog.sv
// Directed bench for clk_divisor_prog: vector table plus hand-written corner sequences.
module tb_clk_divisor_prog;

   logic       clk_hf = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] div_in;
   logic       div_valid;
   logic       div_ready;
   logic       div_err;
   logic       clk;
   logic       tick;
   logic       running;

   int checks   = 0;
   int failures = 0;

   always #5 clk_hf = ~clk_hf;

   clk_divisor_prog #(
      .DIV_W   (8),
      .DEF_DIV (4)
   ) dut (
      .clk_hf    (clk_hf),
      .rst_n     (rst_n),
      .en        (en),
      .div_in    (div_in),
      .div_valid (div_valid),
      .div_ready (div_ready),
      .div_err   (div_err),
      .clk       (clk),
      .tick      (tick),
      .running   (running)
   );

   typedef struct {
      logic       rst_n;
      logic       en;
      logic       dv;
      logic [7:0] din;
      logic       e_clk;
      logic       e_tick;
      logic       e_run;
      logic       e_rdy;
      logic       e_err;
   } vec_t;

   vec_t vecs[28];

   task automatic step();
      @(posedge clk_hf);
      #1;
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b required=%0b", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic e_clk, input logic e_tick,
                          input logic e_run, input logic e_rdy, input logic e_err);
      chk($sformatf("%s.clk", name), clk, e_clk);
      chk($sformatf("%s.tick", name), tick, e_tick);
      chk($sformatf("%s.running", name), running, e_run);
      chk($sformatf("%s.div_ready", name), div_ready, e_rdy);
      chk($sformatf("%s.div_err", name), div_err, e_err);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      en        = 1'b0;
      div_valid = 1'b0;
      div_in    = 8'd0;
      step();
      chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b1;
   endtask

   // Load a divisor while stopped: ready drops for one cycle, then returns.
   task automatic prog(input logic [7:0] v);
      div_in    = v;
      div_valid = 1'b1;
      step();
      chk($sformatf("prog%0d.ready_low", v), div_ready, 1'b0);
      div_valid = 1'b0;
      step();
      chk($sformatf("prog%0d.ready_high", v), div_ready, 1'b1);
   endtask

   initial begin
      int hi;
      rst_n     = 1'b0;
      en        = 1'b0;
      div_valid = 1'b0;
      div_in    = 8'd0;

      //          rst  en   dv   din    clk  tick run  rdy  err
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      // div_in=5 offered during the cnt=1 cycle; old period still completes 1100.
      vecs[16] = '{1'b1, 1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[17] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[18] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[19] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[20] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[21] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[22] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[23] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[24] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[25] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[26] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[27] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

      for (int i = 0; i < 28; i++) begin
         rst_n     = vecs[i].rst_n;
         en        = vecs[i].en;
         div_valid = vecs[i].dv;
         div_in    = vecs[i].din;
         step();
         chk_out($sformatf("vec%0d", i), vecs[i].e_clk, vecs[i].e_tick, vecs[i].e_run,
                 vecs[i].e_rdy, vecs[i].e_err);
      end

      // en dropped at cnt=1 with N=6: period completes 111000, then stop.
      do_reset();
      prog(8'd6);
      en = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("stop6.c%0d.clk", i), clk, (i < 3));
         chk($sformatf("stop6.c%0d.tick", i), tick, (i == 0));
         chk($sformatf("stop6.c%0d.running", i), running, 1'b1);
         if (i == 1) en = 1'b0;
         step();
      end
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("stop6.idle%0d.clk", i), clk, 1'b0);
         chk($sformatf("stop6.idle%0d.tick", i), tick, 1'b0);
         chk($sformatf("stop6.idle%0d.running", i), running, 1'b0);
         step();
      end
      en = 1'b1;
      step();
      chk_out("restart6", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

      // Reset at cnt=2 with N=5 and 7 pending: pending is dropped, N returns to 4.
      do_reset();
      prog(8'd5);
      en = 1'b1;
      step();
      chk("rst5.c0.tick", tick, 1'b1);
      step();
      div_in    = 8'd7;
      div_valid = 1'b1;
      step();
      chk("rst5.c2.clk", clk, 1'b1);
      chk("rst5.c2.ready", div_ready, 1'b0);
      div_valid = 1'b0;
      rst_n     = 1'b0;
      step();
      chk_out("rst5.inreset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("rst5.after%0d.clk", i), clk, ((i % 4) < 2));
         chk($sformatf("rst5.after%0d.tick", i), tick, ((i % 4) == 0));
         chk($sformatf("rst5.after%0d.ready", i), div_ready, 1'b1);
         step();
      end

      // Divisor 255: 128 high, 127 low, three full periods.
      do_reset();
      prog(8'd255);
      en = 1'b1;
      step();
      hi = 0;
      for (int i = 0; i < 3 * 255; i++) begin
         chk($sformatf("d255.c%0d.clk", i), clk, ((i % 255) < 128));
         chk($sformatf("d255.c%0d.tick", i), tick, ((i % 255) == 0));
         if (clk === 1'b1) hi++;
         step();
      end
      checks++;
      if (hi != 384) begin
         failures++;
         $display("FAIL d255.high_total actual=%0d required=384", hi);
      end
      chk("d255.next_period.tick", tick, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clk_divisor_prog.md
CLK_DIVISOR_PROG -- requirements
Module: clk_divisor_prog

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of divisor and period counter.
REQ-002 SHALL have parameter DEF_DIV, default 4: divisor loaded at reset; legal range 2..2^DIV_W-1.
REQ-003 SHALL have port clk_hf  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  run request for divided output.
REQ-006 SHALL have port div_in  input  DIV_W  new divisor value N.
REQ-007 SHALL have port div_valid  input  1  div_in offered this cycle.
REQ-008 SHALL have port div_ready  output  1  block can accept a divisor.
REQ-009 SHALL have port div_err  output  1  one-cycle pulse: offered divisor rejected.
REQ-010 SHALL have port clk  output  1  registered divided clock.
REQ-011 SHALL have port tick  output  1  one-cycle strobe marking each divided-clock rising edge.
REQ-012 SHALL have port running  output  1  divider active.

Function
REQ-013 SHALL hold active divisor N, period counter cnt (0..N-1), pending divisor P with pending flag, and state STOP/RUN.
REQ-014 In RUN, SHALL increment cnt each cycle and wrap from N-1 to 0; a wrap is a period boundary.
REQ-015 In RUN, SHALL drive clk high in cycles with cnt < ceil(N/2) and low otherwise; odd N gives one extra high cycle.
REQ-016 SHALL assert tick exactly in cycles where state is RUN and cnt==0, aligned with the clk low-to-high transition.
REQ-017 SHALL register all outputs, with no combinational path from inputs to outputs.
REQ-018 Handshake: a divisor SHALL be accepted only in a cycle where div_valid and div_ready are both high.
REQ-019 SHALL reject an accepted div_in < 2 by pulsing div_err the next cycle and leaving N and P unchanged.
REQ-020 SHALL store a legal accepted value in P, set pending, and drop div_ready the next cycle.
REQ-021 In RUN, SHALL move P into N at the next period boundary, so the new period starts at cnt=0 with no truncated or glitched phase.
REQ-022 In STOP, SHALL move P into N on the cycle after acceptance.
REQ-023 SHALL clear pending and raise div_ready in the cycle after P is applied.
REQ-024 STOP->RUN: when en is high, SHALL enter RUN next cycle with cnt=0, clk high and tick high in that first cycle.
REQ-025 RUN->STOP: when en is low at a period boundary (cnt==N-1), SHALL enter STOP next cycle.
REQ-026 While en is low mid-period, SHALL finish the current period and leave no runt pulse.
REQ-027 In STOP, SHALL hold clk=0, tick=0, running=0 and cnt=0.
REQ-028 When en falls and a divisor is applied at the same boundary, SHALL apply the divisor and enter STOP.
REQ-029 SHALL hold running=1 exactly while in RUN.

Reset
REQ-030 When rst_n is sampled low at a clk_hf edge, SHALL set N=DEF_DIV, cnt=0, pending=0, state=STOP, clk=0, tick=0, running=0, div_err=0 and div_ready=1.
REQ-031 Reset asserted mid-period SHALL win over every other event, dropping any pending divisor and forcing clk low on the next edge.

Structure
REQ-032 Shared constants package/header SHALL hold the DIV_W default, DEF_DIV default, minimum-divisor constant (2) and the STOP/RUN state encoding.
REQ-033 Period counter with wrap detect SHALL be one sub-module, clk_div_counter: inputs clear, enable and limit; outputs count and wrap.
REQ-034 SHALL synthesise within the 120-400 line RTL budget with no latches and no logic clocked by clk.

Verification
REQ-035 Reset, DIV_W=8, DEF_DIV=4, en=1 -> running rises 1 cycle after en, clk pattern 1100 repeating, tick every 4th cycle starting on the first RUN cycle.
REQ-036 Running at N=4, offer div_in=5 at cnt=1 -> div_ready low from next cycle; current period completes 1100; following periods 11100; div_ready high 1 cycle after the switch.
REQ-037 Offer div_in=1, then div_in=0 -> div_err pulses once per offer, and the clk pattern is unchanged.
REQ-038 en dropped at cnt=1 with N=6 -> period finishes 111000, then clk=0, running=0; en re-raised -> clk high next cycle with tick.
REQ-039 rst_n low for 1 cycle at cnt=2 with N=5 and a pending divisor of 7 -> next cycle all outputs at reset values, N=4 and pending cleared.
REQ-040 Divisor 255 with en=1 -> 128 cycles high, 127 low, no counter overflow across 3 periods.
